// File: rtl/pipa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipa_pkg
//  Description : Shared constants, types and the saturating-add helper for the
//                PIPA moding decoder (axis indices, axis count, saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipa_pkg;

    localparam int NUM_AXES = 3;
    localparam int AX_X     = 0;
    localparam int AX_Y     = 1;
    localparam int AX_Z     = 2;

    // One bit per axis, indexed by AX_X / AX_Y / AX_Z.
    typedef logic [NUM_AXES-1:0] axis_vec_t;

    // Adds delta to acc and clips the result symmetrically to
    // +/-(2^(width-1)-1). The most negative code is deliberately never
    // produced so that the accumulator range stays symmetric.
    function automatic int sat_add(input int acc, input int delta, input int width);
        int lim;
        int sum;
        lim = (1 << (width - 1)) - 1;
        sum = acc + delta;
        if (sum > lim) begin
            return lim;
        end
        if (sum < -lim) begin
            return -lim;
        end
        return sum;
    endfunction

endpackage : pipa_pkg
`default_nettype wire

// File: rtl/pipa_axis_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pipa_axis_decoder
//  Description : One accelerometer axis: per-frame plus/minus tallies, signed
//                saturating pending accumulator and the PINC/MINC
//                request/acknowledge handshake.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          clock (rising edge)
//    rst          asynchronous active-high reset
//    i_dat_stb    one-cycle PIPDAT edge event
//    i_plus       synchronized plus line for this axis
//    i_minus      synchronized minus line for this axis
//    i_frame_end  one-cycle frame-end event (wrapping PIPASW edge)
//    i_inc_ack    one-cycle acknowledge from the counter-increment logic
//    o_pinc_req   registered (pending > 0)
//    o_minc_req   registered (pending < 0)
//    o_clip       combinational: this cycle's pending update was clipped
// ============================================================================
module pipa_axis_decoder
    import pipa_pkg::*;
#(
    parameter int FRAME_LEN = 6,
    parameter int PEND_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dat_stb,
    input  logic i_plus,
    input  logic i_minus,
    input  logic i_frame_end,
    input  logic i_inc_ack,
    output logic o_pinc_req,
    output logic o_minc_req,
    output logic o_clip
);

    localparam int                  TALLY_W   = $clog2(FRAME_LEN + 1);
    localparam logic [TALLY_W-1:0]  TALLY_MAX = '1;

    logic [TALLY_W-1:0]       r_tally_p;
    logic [TALLY_W-1:0]       r_tally_m;
    logic signed [PEND_W-1:0] r_pending;

    logic                     w_hit_p;
    logic                     w_hit_m;
    logic                     w_pend_pos;
    logic                     w_pend_neg;
    int                       w_net;
    int                       w_step;
    int                       w_sum;
    int                       w_sat;
    logic signed [PEND_W-1:0] w_pend_next;

    // Exactly one line high makes a valid sample; both or neither is dropped.
    assign w_hit_p = i_dat_stb & i_plus & ~i_minus;
    assign w_hit_m = i_dat_stb & i_minus & ~i_plus;

    assign w_pend_pos = ~r_pending[PEND_W-1] & (r_pending != '0);
    assign w_pend_neg = r_pending[PEND_W-1];

    always_comb begin
        w_net       = 0;
        w_step      = 0;
        w_sum       = 0;
        w_sat       = 0;
        w_pend_next = r_pending;
        o_clip      = 1'b0;

        // A sample arriving on the closing edge still belongs to this frame,
        // so it is folded into the net directly instead of via the tally.
        if (i_frame_end) begin
            w_net = int'(r_tally_p) + int'(w_hit_p) - int'(r_tally_m) - int'(w_hit_m);
        end

        // The request lags pending by one cycle, so an ACK is only honoured
        // while pending is still non-zero in the requested direction; this
        // keeps back-to-back ACKs from overshooting past zero.
        if (i_inc_ack) begin
            if (o_pinc_req && w_pend_pos) begin
                w_step = 1;
            end else if (o_minc_req && w_pend_neg) begin
                w_step = -1;
            end
        end

        // Frame add and ACK are combined before a single saturation.
        w_sum       = int'(r_pending) + w_net - w_step;
        w_sat       = sat_add(int'(r_pending), w_net - w_step, PEND_W);
        w_pend_next = PEND_W'(w_sat);
        o_clip      = (w_sat != w_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tally_p  <= '0;
            r_tally_m  <= '0;
            r_pending  <= '0;
            o_pinc_req <= 1'b0;
            o_minc_req <= 1'b0;
        end else begin
            if (i_frame_end) begin
                r_tally_p <= '0;
                r_tally_m <= '0;
            end else begin
                // Tallies hold at full scale if PIPASW stops arriving.
                if (w_hit_p && (r_tally_p != TALLY_MAX)) begin
                    r_tally_p <= r_tally_p + TALLY_W'(1);
                end
                if (w_hit_m && (r_tally_m != TALLY_MAX)) begin
                    r_tally_m <= r_tally_m + TALLY_W'(1);
                end
            end
            r_pending  <= w_pend_next;
            o_pinc_req <= w_pend_pos;
            o_minc_req <= w_pend_neg;
        end
    end

endmodule : pipa_axis_decoder
`default_nettype wire

// File: rtl/pipa_moding_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pipa_moding_decoder
//  Description : Receive-side decoder for PIPA accelerometer pulse trains on
//                X/Y/Z. Synchronizes the AGC strobes and pulse lines, tracks
//                the moding slot counter, accumulates per-frame net counts
//                and drains them over a PINC/MINC request/ACK handshake.
//  Revision    : 1.0 - initial release
//
//  Build option
//    PIPA_FAULT_DETECT_EN  defined  : invalid-sample and missing-pulse
//                                     detection drive PIPA_FAIL
//                          undefined: PIPA_FAIL tied low
//
//  Ports
//    SIM_CLK    clock (rising edge)
//    SIM_RST    asynchronous active-high reset
//    PIPASW     async slot-advance strobe, rising edge is the event
//    PIPDAT     async data strobe, rising edge is the event
//    PIPAP[2:0] async plus lines  ([0]=X [1]=Y [2]=Z)
//    PIPAM[2:0] async minus lines (same indexing)
//    INC_ACK    one-cycle acknowledge per axis
//    FAIL_CLR   synchronous clear of PIPA_FAIL / CNT_OVF
//    PINC_REQ   plus-increment request per axis
//    MINC_REQ   minus-increment request per axis
//    FRAME_STB  one-cycle pulse at each frame end
//    PIPA_FAIL  sticky moding-fault flag
//    CNT_OVF    sticky pending-saturation flag
// ============================================================================
module pipa_moding_decoder
    import pipa_pkg::*;
#(
    parameter int FRAME_LEN   = 6,
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4
) (
    input  logic                SIM_CLK,
    input  logic                SIM_RST,
    input  logic                PIPASW,
    input  logic                PIPDAT,
    input  logic [NUM_AXES-1:0] PIPAP,
    input  logic [NUM_AXES-1:0] PIPAM,
    input  logic [NUM_AXES-1:0] INC_ACK,
    input  logic                FAIL_CLR,
    output logic [NUM_AXES-1:0] PINC_REQ,
    output logic [NUM_AXES-1:0] MINC_REQ,
    output logic                FRAME_STB,
    output logic                PIPA_FAIL,
    output logic                CNT_OVF
);

    // Synchronizer bit map: [0]=PIPASW [1]=PIPDAT [2 +: 3]=PIPAP [5 +: 3]=PIPAM
    localparam int                 SYNC_W    = 2 + 2 * NUM_AXES;
    localparam int                 SLOT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(FRAME_LEN - 1);

    logic [SYNC_STAGES-1:0][SYNC_W-1:0] r_sync;
    logic [SYNC_W-1:0]                  w_async_in;
    logic [SYNC_W-1:0]                  w_sync;
    logic                               w_sw_sync;
    logic                               w_dat_sync;
    axis_vec_t                          w_ap_sync;
    axis_vec_t                          w_am_sync;

    logic                               r_sw_prev;
    logic                               r_dat_prev;
    logic                               w_sw_edge;
    logic                               w_dat_edge;

    logic [SLOT_W-1:0]                  r_slot;
    logic                               w_frame_end;
    axis_vec_t                          w_clip;

    // ------------------------------------------------------------------
    // Synchronizers and edge detectors
    // ------------------------------------------------------------------
    assign w_async_in = {PIPAM, PIPAP, PIPDAT, PIPASW};

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_async_in};
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_sw_sync  = w_sync[0];
    assign w_dat_sync = w_sync[1];
    assign w_ap_sync  = w_sync[2 +: NUM_AXES];
    assign w_am_sync  = w_sync[2 + NUM_AXES +: NUM_AXES];

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_sw_prev  <= 1'b0;
            r_dat_prev <= 1'b0;
        end else begin
            r_sw_prev  <= w_sw_sync;
            r_dat_prev <= w_dat_sync;
        end
    end

    assign w_sw_edge  = w_sw_sync & ~r_sw_prev;
    assign w_dat_edge = w_dat_sync & ~r_dat_prev;

    // ------------------------------------------------------------------
    // Slot counter and frame strobe
    // ------------------------------------------------------------------
    assign w_frame_end = w_sw_edge && (r_slot == SLOT_LAST);

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_slot    <= '0;
            FRAME_STB <= 1'b0;
        end else begin
            if (w_sw_edge) begin
                r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
            end
            FRAME_STB <= w_frame_end;
        end
    end

    // ------------------------------------------------------------------
    // Per-axis decoders
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
            pipa_axis_decoder #(
                .FRAME_LEN (FRAME_LEN),
                .PEND_W    (PEND_W)
            ) u_axis (
                .clk         (SIM_CLK),
                .rst         (SIM_RST),
                .i_dat_stb   (w_dat_edge),
                .i_plus      (w_ap_sync[g]),
                .i_minus     (w_am_sync[g]),
                .i_frame_end (w_frame_end),
                .i_inc_ack   (INC_ACK[g]),
                .o_pinc_req  (PINC_REQ[g]),
                .o_minc_req  (MINC_REQ[g]),
                .o_clip      (w_clip[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sticky flags: a new event wins over a same-cycle clear
    // ------------------------------------------------------------------
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            CNT_OVF <= 1'b0;
        end else if (|w_clip) begin
            CNT_OVF <= 1'b1;
        end else if (FAIL_CLR) begin
            CNT_OVF <= 1'b0;
        end
    end

`ifdef PIPA_FAULT_DETECT_EN
    logic r_seen_dat;
    logic r_first_edge;
    logic w_invalid;
    logic w_missing;

    assign w_invalid = w_dat_edge && (|(~(w_ap_sync ^ w_am_sync)));

    // A PIPDAT edge coincident with PIPASW belongs to the closing slot, so
    // it satisfies that slot's pulse check.
    assign w_missing = w_sw_edge && !r_first_edge && !(r_seen_dat || w_dat_edge);

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_seen_dat   <= 1'b0;
            r_first_edge <= 1'b1;
            PIPA_FAIL    <= 1'b0;
        end else begin
            if (w_sw_edge) begin
                r_seen_dat   <= 1'b0;
                r_first_edge <= 1'b0;
            end else if (w_dat_edge) begin
                r_seen_dat <= 1'b1;
            end

            if (w_invalid || w_missing) begin
                PIPA_FAIL <= 1'b1;
            end else if (FAIL_CLR) begin
                PIPA_FAIL <= 1'b0;
            end
        end
    end
`else
    assign PIPA_FAIL = 1'b0;
`endif

endmodule : pipa_moding_decoder
`default_nettype wire

// File: doc/pipa_moding_decoder.md
# pipa_moding_decoder

Receive-side decoder for PIPA accelerometer pulse trains on three axes (X, Y, Z), driven by the AGC's PIPASW/PIPDAT interrogation strobes. Each PIPDAT strobe delivers one sample per axis on that axis's plus and minus lines. PIPASW advances a shared slot counter, and every FRAME_LEN slots the net count for each axis is added to a pending accumulator. Pending counts drain one at a time to the counter-increment logic over a PINC/MINC request/acknowledge handshake. The block also flags moding faults.

## Interface
- FRAME_LEN, 6, slots per moding frame (3-3 moding gives net 0).
- SYNC_STAGES, 2, synchronizer flops on every async input (≥2).
- PEND_W, 4, signed pending-accumulator width per axis.

- SIM_CLK  in  1  sole clock; all state is clocked on its rising edge.
- SIM_RST  in  1  asynchronous, active-high reset.
- PIPASW  in  1  slot-advance strobe (async level; rising edge is the event).
- PIPDAT  in  1  data strobe (async level; rising edge is the event).
- PIPAP  in  3  plus pulse lines [0]=X [1]=Y [2]=Z (async).
- PIPAM  in  3  minus pulse lines, same indexing (async).
- INC_ACK  in  3  one-cycle acknowledge per axis.
- FAIL_CLR  in  1  synchronous clear of the sticky flags.
- PINC_REQ  out  3  plus-increment request per axis.
- MINC_REQ  out  3  minus-increment request per axis.
- FRAME_STB  out  1  one-cycle pulse at each frame end.
- PIPA_FAIL  out  1  sticky moding-fault flag.
- CNT_OVF  out  1  sticky pending-saturation flag.

## Operation
- All async inputs pass through a SYNC_STAGES synchronizer, then an edge-detect register. An "edge" below means a rising edge of the synchronized signal.
- PIPDAT edge handling:
  - In the same cycle, capture the synchronized PIPAP/PIPAM for each axis.
  - Plus only: tally_p += 1. Minus only: tally_m += 1.
  - Both lines high, or neither: the sample is invalid, is not counted, and sets PIPA_FAIL.
  - Set the seen_dat flag.
- PIPASW edge handling:
  - The slot counter advances 0..FRAME_LEN-1 and wraps.
  - If seen_dat is clear and this is not the first PIPASW edge after reset, set PIPA_FAIL (missing pulse).
  - Clear seen_dat.
- Frame end is the PIPASW edge that wraps FRAME_LEN-1 to 0. On frame end, for each axis:
  - pending += tally_p − tally_m.
  - Clear the tallies.
  - Pulse FRAME_STB.
- A PIPDAT edge in the same cycle as a PIPASW edge counts into the closing slot and frame.
- Pending accumulator:
  - Signed PEND_W bits, saturating at ±(2^(PEND_W−1)−1).
  - Any clipping sets CNT_OVF.
- Handshake, per axis:
  - PINC_REQ = registered (pending > 0); MINC_REQ = registered (pending < 0). The two are never both high.
  - INC_ACK while a request is high moves pending one step toward 0.
  - INC_ACK while no request is high is ignored.
  - A frame add and an ACK in the same cycle combine: pending_next = sat(pending + net − ack_step). Saturation applies to the combined result.
- FAIL_CLR clears PIPA_FAIL and CNT_OVF. A fault event in the same cycle as FAIL_CLR takes priority, so the flag stays set.

## Timing
- Reset values:
  - Slot counter 0, tallies 0, pending 0.
  - seen_dat 0; the first-edge flag is set so that the first PIPASW edge is not checked.
  - All outputs 0.
- Latency from an async input rising to its edge event: SYNC_STAGES+1 cycles.
- A frame-end event updates pending and FRAME_STB on the next clock edge. PINC_REQ/MINC_REQ reflect the new pending one cycle after that.
- After an accepted ACK, the request updates one cycle later. A request deasserts only when pending reaches 0.
- Back-to-back ACKs on consecutive cycles each take effect.
- Reset mid-frame discards the partial tallies and pending. Requests drop immediately, asynchronously.
- Timing between PIPASW and PIPDAT strobes is unconstrained beyond each high and low phase lasting ≥ SYNC_STAGES+1 cycles.

## Configuration
- PIPA_FAULT_DETECT_EN defined: invalid-sample and missing-pulse detection active, and PIPA_FAIL is driven.
- PIPA_FAULT_DETECT_EN undefined:
  - PIPA_FAIL is tied to 0 and the seen_dat and first-edge logic is removed.
  - Invalid samples are still not counted.
  - CNT_OVF is unaffected.

## Structure
- Shared package pipa_pkg holds the axis index constants (AX_X=0, AX_Y=1, AX_Z=2), the NUM_AXES=3 constant, and the saturating-add function.
- Sub-module pipa_axis_decoder, instantiated three times, holds one axis's tallies, pending accumulator, saturation logic and handshake.
- The top level holds the synchronizers, edge detectors, slot counter, fault flags and FRAME_STB.

## Test plan
- Nominal 3-3 moding:
  - Stimulus: 10 frames, slot pattern +,+,+,−,−,− on all axes.
  - Required: FRAME_STB ×10, requests never assert, PIPA_FAIL=0, CNT_OVF=0.
- 4-2 frame on X only:
  - Stimulus: one frame with X pattern +,+,+,+,−,−; Y and Z 3-3.
  - Required: PINC_REQ[0] high until exactly 2 ACKs are given, then low. No Y or Z requests.
- Saturation:
  - Stimulus: 3 all-plus frames on Z with no ACK (net +18).
  - Required: pending clips at +7 (PEND_W=4), CNT_OVF=1.
  - Then 7 ACKs drop PINC_REQ[2]; FAIL_CLR clears CNT_OVF.
- Faults (PIPA_FAULT_DETECT_EN defined):
  - Sample with PIPAP[1]=PIPAM[1]=1 → PIPA_FAIL=1, Y tally unchanged.
  - Two PIPASW edges with no PIPDAT between them → PIPA_FAIL=1.
  - Same stimuli without the macro → PIPA_FAIL stays 0.
- Simultaneous events:
  - Stimulus: X pending=−1, MINC_REQ[0] high; INC_ACK[0] arrives in the same cycle as a frame end with X net −2.
  - Required: pending=−2, MINC_REQ[0] stays high.
- Reset mid-frame:
  - Stimulus: assert SIM_RST after 3 slots with pending=+3.
  - Required: all outputs 0 immediately. The next 6 PIPASW edges produce one FRAME_STB, and the first edge raises no missing-pulse fault.
